// File: rtl/board_pkg.sv
// board_pkg: shared definitions for the board_state slice.
// Holds the board geometry, the cell code type and values, the initial
// cursor position and the placement FSM state encoding.
package board_pkg;

  localparam int N      = 5;
  localparam int CELL_W = 8;

  typedef logic [CELL_W-1:0] cell_t;

  localparam cell_t CELL_EMPTY = 8'h00;
  localparam cell_t CELL_P1    = 8'h01;
  localparam cell_t CELL_P2    = 8'h02;

  localparam logic [2:0] CUR_INIT = 3'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    WRITE  = 2'd2,
    REJECT = 2'd3
  } place_st_t;

endpackage

// File: rtl/board_state_if.sv
// board_state_if: place-request handshake between a requester and board_state.
//   place_req : request to place the current player's code at the cursor
//   place_ack : one-cycle completion pulse
//   place_ok  : qualifies place_ack (1 = written, 0 = rejected)
// master = requester side, slave = board_state side.
interface board_state_if;

  logic place_req;
  logic place_ack;
  logic place_ok;

  modport master (output place_req, input place_ack, input place_ok);
  modport slave  (input place_req, output place_ack, output place_ok);

endinterface

// File: rtl/board_state_cursor_ctrl.sv
// cursor_ctrl: player cursor for the 5x5 board.
// Applies at most one move per cycle (up > down > left > right) and only
// while mv_en is high. clear returns the cursor to (CUR_INIT, CUR_INIT).
// Edge behaviour is selected by macro BOARD_CURSOR_WRAP_EN: defined = wrap
// around, undefined = saturate at the edges.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   clear                  : return cursor to the centre
//   mv_en                  : moves are honoured only when high
//   mv_up/down/left/right  : one-cycle move pulses
//   cur_row, cur_col       : registered cursor position
module cursor_ctrl
  import board_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       mv_en,
  input  logic       mv_up,
  input  logic       mv_down,
  input  logic       mv_left,
  input  logic       mv_right,
  output logic [2:0] cur_row,
  output logic [2:0] cur_col
);

  localparam logic [2:0] POS_MAX = 3'(N - 1);

  function automatic logic [2:0] step_dec(input logic [2:0] v);
`ifdef BOARD_CURSOR_WRAP_EN
    return (v == 3'd0) ? POS_MAX : v - 3'd1;
`else
    return (v == 3'd0) ? 3'd0 : v - 3'd1;
`endif
  endfunction

  function automatic logic [2:0] step_inc(input logic [2:0] v);
`ifdef BOARD_CURSOR_WRAP_EN
    return (v == POS_MAX) ? 3'd0 : v + 3'd1;
`else
    return (v == POS_MAX) ? POS_MAX : v + 3'd1;
`endif
  endfunction

  logic [2:0] row_q, row_d;
  logic [2:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = CUR_INIT;
      col_d = CUR_INIT;
    end else if (mv_en) begin
      if (mv_up)         row_d = step_dec(row_q);
      else if (mv_down)  row_d = step_inc(row_q);
      else if (mv_left)  col_d = step_dec(col_q);
      else if (mv_right) col_d = step_inc(col_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= CUR_INIT;
      col_q <= CUR_INIT;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign cur_row = row_q;
  assign cur_col = col_q;

endmodule

// File: rtl/board_state.sv
// board_state: owner of the 5x5 game board feeding the flattening stage.
// Holds the cell codes, cursor, turn and occupancy count, and runs the
// place-request handshake that writes the current player's code into the
// cursor cell when it is empty.
// Optional macro BOARD_CURSOR_WRAP_EN selects wrap-around cursor moves
// (handled in cursor_ctrl); the default build saturates at the edges.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   clear                 : empty board, cursor (2,2), turn 0, abort request
//   mv_up/down/left/right : debounced one-cycle cursor moves
//   bus (slave)           : place_req in, place_ack / place_ok out
//   matriz                : registered board, matriz[row][col]
//   cur_row, cur_col      : cursor position
//   turn                  : current player (0 = P1, 1 = P2)
//   occupied, board_full  : non-empty cell count and its ==25 flag
//
// state  | meaning
// IDLE   | accepts moves and place requests; latches target on request
// CHECK  | tests the latched cell; board update and ack registered here
// WRITE  | ack with ok=1 visible, board/turn/count already updated
// REJECT | ack with ok=0 visible, nothing changed
module board_state
  import board_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                mv_up,
  input  logic                mv_down,
  input  logic                mv_left,
  input  logic                mv_right,
  board_state_if.slave        bus,
  output cell_t               matriz [0:N-1][0:N-1],
  output logic [2:0]          cur_row,
  output logic [2:0]          cur_col,
  output logic                turn,
  output logic [4:0]          occupied,
  output logic                board_full
);

  place_st_t  state_q, state_d;

  cell_t      board_q [0:N-1][0:N-1];
  cell_t      board_d [0:N-1][0:N-1];
  logic [2:0] tgt_row_q, tgt_row_d;
  logic [2:0] tgt_col_q, tgt_col_d;
  cell_t      player_q, player_d;
  logic       turn_q, turn_d;
  logic [4:0] occ_q, occ_d;
  logic       full_q, full_d;
  logic       ack_q, ack_d;
  logic       ok_q, ok_d;

  logic       latch_en;
  logic       wr_en;
  logic       tgt_empty;

  cursor_ctrl u_cursor (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .mv_en    (state_q == IDLE),
    .mv_up    (mv_up),
    .mv_down  (mv_down),
    .mv_left  (mv_left),
    .mv_right (mv_right),
    .cur_row  (cur_row),
    .cur_col  (cur_col)
  );

  assign tgt_empty = (board_q[tgt_row_q][tgt_col_q] == CELL_EMPTY);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:          if (bus.place_req) state_d = CHECK;
        CHECK:         state_d = tgt_empty ? WRITE : REJECT;
        WRITE, REJECT: state_d = IDLE;
        default:       state_d = IDLE;
      endcase
    end
  end

  // FSM outputs. The ack/ok flops and the board update are loaded on the
  // CHECK exit edge so that they are visible throughout WRITE/REJECT.
  always_comb begin
    latch_en = 1'b0;
    wr_en    = 1'b0;
    ack_d    = 1'b0;
    ok_d     = 1'b0;
    if (!clear) begin
      case (state_q)
        IDLE:  latch_en = bus.place_req;
        CHECK: begin
          ack_d = 1'b1;
          ok_d  = tgt_empty;
          wr_en = tgt_empty;
        end
        default: ;
      endcase
    end
  end

  // Datapath: target latch, board, turn and occupancy.
  always_comb begin
    tgt_row_d = tgt_row_q;
    tgt_col_d = tgt_col_q;
    player_d  = player_q;
    board_d   = board_q;
    turn_d    = turn_q;
    occ_d     = occ_q;
    if (latch_en) begin
      // cursor outputs still hold the pre-move position this cycle
      tgt_row_d = cur_row;
      tgt_col_d = cur_col;
      player_d  = turn_q ? CELL_P2 : CELL_P1;
    end
    if (clear) begin
      board_d = '{default: CELL_EMPTY};
      turn_d  = 1'b0;
      occ_d   = 5'd0;
    end else if (wr_en) begin
      board_d[tgt_row_q][tgt_col_q] = player_q;
      turn_d = ~turn_q;
      occ_d  = occ_q + 5'd1;
    end
    full_d = (occ_d == 5'(N * N));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      board_q   <= '{default: CELL_EMPTY};
      tgt_row_q <= CUR_INIT;
      tgt_col_q <= CUR_INIT;
      player_q  <= CELL_P1;
      turn_q    <= 1'b0;
      occ_q     <= 5'd0;
      full_q    <= 1'b0;
      ack_q     <= 1'b0;
      ok_q      <= 1'b0;
    end else begin
      board_q   <= board_d;
      tgt_row_q <= tgt_row_d;
      tgt_col_q <= tgt_col_d;
      player_q  <= player_d;
      turn_q    <= turn_d;
      occ_q     <= occ_d;
      full_q    <= full_d;
      ack_q     <= ack_d;
      ok_q      <= ok_d;
    end
  end

  assign matriz        = board_q;
  assign turn          = turn_q;
  assign occupied      = occ_q;
  assign board_full    = full_q;
  assign bus.place_ack = ack_q;
  assign bus.place_ok  = ok_q;

endmodule

// File: tb/tb_board_state.sv
// Directed bench for board_state with a scoreboard of expected placements.
module tb_board_state;
  import board_pkg::*;

  logic       clk = 1'b0;
  logic       rst, clear, mv_up, mv_down, mv_left, mv_right;
  cell_t      matriz [0:N-1][0:N-1];
  logic [2:0] cur_row, cur_col;
  logic       turn;
  logic [4:0] occupied;
  logic       board_full;

  board_state_if bif ();

  board_state dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .mv_up      (mv_up),
    .mv_down    (mv_down),
    .mv_left    (mv_left),
    .mv_right   (mv_right),
    .bus        (bif.slave),
    .matriz     (matriz),
    .cur_row    (cur_row),
    .cur_col    (cur_col),
    .turn       (turn),
    .occupied   (occupied),
    .board_full (board_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       ok;
    logic [2:0] row, col;
    cell_t      code;
    logic       turn;
    logic [4:0] occ;
    logic       full;
    logic [2:0] crow, ccol;
  } exp_t;

  exp_t sb [$];

  int vectors     = 0;
  int miscompares = 0;

  cell_t      m_board [0:N-1][0:N-1];
  logic [2:0] m_row, m_col;
  logic       m_turn;
  logic [4:0] m_occ;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [2:0] m_dec(input logic [2:0] v);
`ifdef BOARD_CURSOR_WRAP_EN
    return (v == 3'd0) ? 3'd4 : v - 3'd1;
`else
    return (v == 3'd0) ? 3'd0 : v - 3'd1;
`endif
  endfunction

  function automatic logic [2:0] m_inc(input logic [2:0] v);
`ifdef BOARD_CURSOR_WRAP_EN
    return (v == 3'd4) ? 3'd0 : v + 3'd1;
`else
    return (v == 3'd4) ? 3'd4 : v + 3'd1;
`endif
  endfunction

  // m = {up, down, left, right}
  function automatic void model_move(input logic [3:0] m);
    if (m[3])      m_row = m_dec(m_row);
    else if (m[2]) m_row = m_inc(m_row);
    else if (m[1]) m_col = m_dec(m_col);
    else if (m[0]) m_col = m_inc(m_col);
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        m_board[r][c] = CELL_EMPTY;
    m_row  = 3'd2;
    m_col  = 3'd2;
    m_turn = 1'b0;
    m_occ  = 5'd0;
  endfunction

  function automatic int board_diff();
    int n = 0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        if (matriz[r][c] !== m_board[r][c]) n++;
    return n;
  endfunction

  task automatic move(input logic [3:0] m);
    @(posedge clk); #1;
    {mv_up, mv_down, mv_left, mv_right} = m;
    @(posedge clk); #1;
    {mv_up, mv_down, mv_left, mv_right} = 4'b0000;
    model_move(m);
    @(negedge clk);
    check("move_row", 32'(cur_row), 32'(m_row));
    check("move_col", 32'(cur_col), 32'(m_col));
  endtask

  task automatic place(input string tag, input logic [3:0] m);
    exp_t e, got_e;
    bit   got;
    e.tag = tag;
    e.row = m_row;
    e.col = m_col;
    e.ok  = (m_board[m_row][m_col] == CELL_EMPTY);
    if (e.ok) begin
      m_board[m_row][m_col] = m_turn ? CELL_P2 : CELL_P1;
      m_turn = ~m_turn;
      m_occ  = m_occ + 5'd1;
    end
    e.code = m_board[e.row][e.col];
    e.turn = m_turn;
    e.occ  = m_occ;
    e.full = (m_occ == 5'd25);
    model_move(m);
    e.crow = m_row;
    e.ccol = m_col;
    sb.push_back(e);

    @(posedge clk); #1;
    bif.place_req = 1'b1;
    {mv_up, mv_down, mv_left, mv_right} = m;
    @(posedge clk); #1;
    bif.place_req = 1'b0;
    {mv_up, mv_down, mv_left, mv_right} = 4'b0000;

    got = 0;
    for (int k = 1; k <= 6 && !got; k++) begin
      @(negedge clk);
      if (bif.place_ack === 1'b1) begin
        got   = 1;
        got_e = sb.pop_front();
        check({got_e.tag, "_latency"}, 32'(k), 32'd2);
        check({got_e.tag, "_ok"}, 32'(bif.place_ok), 32'(got_e.ok));
        check({got_e.tag, "_cell"}, 32'(matriz[got_e.row][got_e.col]), 32'(got_e.code));
        check({got_e.tag, "_turn"}, 32'(turn), 32'(got_e.turn));
        check({got_e.tag, "_occ"}, 32'(occupied), 32'(got_e.occ));
        check({got_e.tag, "_full"}, 32'(board_full), 32'(got_e.full));
        check({got_e.tag, "_cur"}, {26'd0, cur_row, cur_col}, {26'd0, got_e.crow, got_e.ccol});
      end else begin
        check({tag, "_ok_without_ack"}, 32'(bif.place_ok), 32'd0);
      end
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $error("FAIL %s_ack: observed no ack expected ack within 6 cycles", tag);
      got_e = sb.pop_front();
    end
    @(posedge clk); #1;
    // ack is a single-cycle pulse
    check({tag, "_ack_drop"}, 32'(bif.place_ack), 32'd0);
  endtask

  task automatic goto_cell(input logic [2:0] r, input logic [2:0] c);
    while (m_row > r) move(4'b1000);
    while (m_row < r) move(4'b0100);
    while (m_col > c) move(4'b0010);
    while (m_col < c) move(4'b0001);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clear = 1'b0;
    mv_up = 1'b0; mv_down = 1'b0; mv_left = 1'b0; mv_right = 1'b0;
    bif.place_req = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    check("rst_board", 32'(board_diff()), 32'd0);
    check("rst_row", 32'(cur_row), 32'd2);
    check("rst_col", 32'(cur_col), 32'd2);
    check("rst_turn", 32'(turn), 32'd0);
    check("rst_occ", 32'(occupied), 32'd0);
    check("rst_full", 32'(board_full), 32'd0);
    check("rst_ack", 32'(bif.place_ack), 32'd0);
    check("rst_ok", 32'(bif.place_ok), 32'd0);

    place("p1_centre", 4'b0000);
    check("p1_cell_const", 32'(matriz[2][2]), 32'h01);
    place("dup_centre", 4'b0000);
    check("dup_cell_const", 32'(matriz[2][2]), 32'h01);

    move(4'b1000);
    move(4'b1000);
    move(4'b1000);
`ifdef BOARD_CURSOR_WRAP_EN
    check("up3_row_const", 32'(cur_row), 32'd4);
`else
    check("up3_row_const", 32'(cur_row), 32'd0);
`endif

    move(4'b1001);  // up beats right
    move(4'b0011);  // left beats right
    place("place_with_move", 4'b0100);
    check("board_after_moves", 32'(board_diff()), 32'd0);

    // clear lands while the FSM is in CHECK
    @(posedge clk); #1;
    bif.place_req = 1'b1;
    @(posedge clk); #1;
    bif.place_req = 1'b0;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_clear();
    @(negedge clk);
    check("clr_board", 32'(board_diff()), 32'd0);
    check("clr_cur", {26'd0, cur_row, cur_col}, {26'd0, 3'd2, 3'd2});
    check("clr_turn", 32'(turn), 32'd0);
    check("clr_occ", 32'(occupied), 32'd0);
    for (int k = 0; k < 4; k++) begin
      check("clr_no_ack", 32'(bif.place_ack), 32'd0);
      @(negedge clk);
    end

    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        goto_cell(3'(r), 3'(c));
        place("fill", 4'b0000);
      end
    @(negedge clk);
    check("fill_occ", 32'(occupied), 32'd25);
    check("fill_full", 32'(board_full), 32'd1);
    check("fill_board", 32'(board_diff()), 32'd0);
    check("fill_corner", 32'(matriz[4][4]), 32'h01);
    place("full_reject", 4'b0000);
    check("full_occ_after", 32'(occupied), 32'd25);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/board_state.md
# board_state

Sequential owner of the 5x5 game board that feeds the board-flattening stage. Holds the 25 cell codes, a player cursor and turn state, and runs a place-request handshake that writes the current player's code into the cursor cell when that cell is empty. Its `matriz` output connects directly to the flattening stage's `matriz` input.

## Interface
- `N`, 5: board dimension; rows and columns 0..N-1.
- `CELL_W`, 8: width of one cell code.
- `clk`  in  1: system clock.
- `rst`  in  1: synchronous, active-high reset.
- `clear`  in  1: one-cycle pulse that empties the board and returns the block to its initial game state.
- `mv_up`, `mv_down`, `mv_left`, `mv_right`  in  1 each: one-cycle cursor move pulses, already debounced.
- `place_req`  in  1: request to place the current player's code at the cursor.
- `place_ack`  out  1: one-cycle completion pulse.
- `place_ok`  out  1: qualifies `place_ack`; 1 = written, 0 = rejected.
- `matriz`  out  [CELL_W-1:0] [0:N-1][0:N-1]: registered board; `matriz[row][col]`.
- `cur_row`, `cur_col`  out  3 each: cursor position.
- `turn`  out  1: current player; 0 = P1, 1 = P2.
- `occupied`  out  5: number of non-empty cells, 0..25.
- `board_full`  out  1: high when `occupied == 25`.

## Operation
- Cell codes are `CELL_EMPTY` = 8'h00, `CELL_P1` = 8'h01 and `CELL_P2` = 8'h02. No other value is ever written.
- FSM states:
  - IDLE: accepts moves and requests.
  - CHECK: tests the latched cell.
  - WRITE: stores the code, pulses ack with ok=1, toggles `turn`, increments `occupied`.
  - REJECT: pulses ack with ok=0; board, turn and count are unchanged.
- Transitions: IDLE -> CHECK on `place_req`. CHECK -> WRITE if the cell is empty, otherwise CHECK -> REJECT. WRITE -> IDLE and REJECT -> IDLE unconditionally.
- The target row/col and the player are latched on the IDLE -> CHECK transition. Later cursor changes do not affect an in-flight placement.
- Moves are acted on only in IDLE; in other states they are dropped.
- Move priority in one cycle: `mv_up` > `mv_down` > `mv_left` > `mv_right`. Only one move is applied.
- A move and `place_req` in the same IDLE cycle: the placement uses the pre-move position and the move is applied.
- `place_req` held high is treated as level: a new request starts each time the FSM is in IDLE.
- Placing on a full board always rejects, because no cell is empty.
- `clear`:
  - All cells go to EMPTY, cursor to (2,2), `turn` to 0, `occupied` to 0, FSM to IDLE.
  - Any in-flight request is aborted with no ack.
  - Priority order is `rst` > `clear` > all else.

## Timing
- Reset values: all `matriz` = 8'h00, `cur_row` = `cur_col` = 2, `turn` = 0, `occupied` = 0, `board_full` = 0, `place_ack` = 0, `place_ok` = 0, FSM = IDLE.
- Request sampled in cycle t (IDLE). CHECK occurs in t+1. Ack appears in t+2, together with the updated `matriz`, `turn` and `occupied`. The FSM is back in IDLE at t+3.
- The earliest next request is accepted at t+3, so a new placement can start every 3 cycles.
- A move pulse in cycle t updates `cur_row`/`cur_col` at t+1.
- `place_ok` is 0 whenever `place_ack` is 0.
- `board_full` is registered and changes in the same cycle as `occupied`.

## Configuration
- Macro `BOARD_CURSOR_WRAP_EN`.
- Defined: moves wrap around the edges. Up from row 0 goes to row 4, right from col 4 goes to col 0, and likewise for the other edges.
- Undefined: moves saturate at the edges. Up at row 0 stays at row 0, right at col 4 stays at col 4.

## Structure
- Shared package `board_pkg` holds:
  - `N`, `CELL_W`;
  - the `cell_t` typedef;
  - the constants `CELL_EMPTY`, `CELL_P1`, `CELL_P2`, `CUR_INIT` = 2;
  - the FSM state enum `place_st_t` (IDLE, CHECK, WRITE, REJECT).
- One sub-module, `cursor_ctrl`: move priority, wrap/saturate logic and the IDLE gating input. The top level holds the board array, FSM and counter.

## Test plan
- Reset, then inspect outputs -> all cells 00, cursor (2,2), turn 0, occupied 0, no ack.
- `place_req` at (2,2) -> ack 2 cycles later with ok=1; `matriz[2][2]` = 01, turn 1, occupied 1.
- Second `place_req` at the same cell -> ack with ok=0; `matriz[2][2]` still 01, turn stays 1, occupied stays 1.
- `mv_up` ×3 from row 2 -> row 0 without the macro; row 4 with `BOARD_CURSOR_WRAP_EN`.
- Fill all 25 cells alternately -> occupied 25, `board_full` 1. A further request is rejected.
- `clear` asserted in the CHECK cycle -> no ack, board empty, cursor (2,2), turn 0 next cycle.
